// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: FSM encodings and
// the released-level helper used to seed the synchroniser.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // Raw input level that means "not pressed" for the given polarity.
    function automatic logic released_level(input int active_low);
        return (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with synchronous active-low reset to RST_VAL.
// Generic enough to condition any asynchronous single-bit control.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronise, require CNT_MAX stable cycles,
// then emit a clean level, press/release pulses and a press counter.
module key_debounce #(
    parameter int CNT_MAX    = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in,
    output logic             key_level,
    output logic             key_press,
    output logic             key_release,
    output logic [CNT_W-1:0] press_cnt
);

    import key_debounce_pkg::*;

    localparam int             CW       = $clog2(CNT_MAX);
    localparam logic           REL      = released_level(ACTIVE_LOW);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

    logic          sync_q;
    logic          key_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_d, press_d, release_d;

    sync_2ff #(
        .RST_VAL (REL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (sync_q)
    );

    // Normalise polarity so key_s = 1 always means pressed.
    assign key_s = sync_q ^ REL;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RELEASED;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            press_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            if (press_d)
                press_cnt <= press_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            S_RELEASED: begin
                if (key_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!key_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                // A bounce back to pressed keeps the level high.
                if (key_s) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce
// (CNT_MAX = 4, active-low key, 8-bit press counter).
module tb_key_debounce;

    logic       clk;
    logic       rst_n;
    logic       key_in;
    logic       key_level;
    logic       key_press;
    logic       key_release;
    logic [7:0] press_cnt;

    int         vectors;
    int         miscompares;
    logic [7:0] exp_cnt;
    logic       both_seen;

    key_debounce #(
        .CNT_MAX    (4),
        .ACTIVE_LOW (1),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .press_cnt   (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (key_press && key_release)
            both_seen = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 1'b0;
        tick();
        vectors++;
        if (key_level !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_level got=%b exp=0", key_level);
        end
        vectors++;
        if (key_press !== 1'b0 || key_release !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses got=%b%b exp=00",
                     key_press, key_release);
        end
        vectors++;
        if (press_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got=%0d exp=0", press_cnt);
        end
        tick();
        key_in = 1'b1;
        rst_n  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (key_press !== 1'b0 || key_level !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d] got=%b%b exp=00",
                         k, key_press, key_level);
            end
        end
        exp_cnt = 8'd0;
    endtask

    task automatic test_clean_press();
        key_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (key_press !== (k == 6)) begin
                miscompares++;
                $display("FAIL press_pulse[%0d] got=%b exp=%b",
                         k, key_press, (k == 6));
            end
            vectors++;
            if (key_level !== (k >= 6)) begin
                miscompares++;
                $display("FAIL press_level[%0d] got=%b exp=%b",
                         k, key_level, (k >= 6));
            end
        end
        exp_cnt = exp_cnt + 8'd1;
        vectors++;
        if (press_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL press_cnt got=%0d exp=%0d", press_cnt, exp_cnt);
        end
    endtask

    task automatic test_release();
        int rel_seen;
        rel_seen = 0;
        key_in = 1'b1;
        tick();
        tick();
        key_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (key_release) rel_seen++;
        end
        vectors++;
        if (rel_seen !== 0 || key_level !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_release got=%0d/%b exp=0/1",
                     rel_seen, key_level);
        end
        key_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (key_release !== (k == 6)) begin
                miscompares++;
                $display("FAIL release_pulse[%0d] got=%b exp=%b",
                         k, key_release, (k == 6));
            end
            vectors++;
            if (key_level !== (k < 6)) begin
                miscompares++;
                $display("FAIL release_level[%0d] got=%b exp=%b",
                         k, key_level, (k < 6));
            end
        end
    endtask

    task automatic test_bounce();
        int early;
        int at;
        early = 0;
        at    = -1;
        for (int k = 0; k < 20; k++) begin
            key_in = ((k / 2) % 2) == 1;
            tick();
            if (key_press) early++;
        end
        vectors++;
        if (early !== 0 || key_level !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_reject got=%0d/%b exp=0/0",
                     early, key_level);
        end
        key_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (key_press) begin
                if (at < 0) at = k;
                else early++;
            end
        end
        vectors++;
        if (at !== 6 || early !== 0) begin
            miscompares++;
            $display("FAIL bounce_press got=edge%0d/extra%0d exp=edge6/extra0",
                     at, early);
        end
        exp_cnt = exp_cnt + 8'd1;
        vectors++;
        if (press_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL bounce_cnt got=%0d exp=%0d", press_cnt, exp_cnt);
        end
        key_in = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_wrap();
        logic [7:0] prev;
        both_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            prev   = exp_cnt;
            key_in = 1'b0;
            repeat (8) tick();
            key_in = 1'b1;
            repeat (8) tick();
            exp_cnt = exp_cnt + 8'd1;
            vectors++;
            if (press_cnt !== exp_cnt) begin
                miscompares++;
                $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d",
                         i, press_cnt, exp_cnt);
            end
            if (prev == 8'd255) begin
                vectors++;
                if (press_cnt !== 8'd0) begin
                    miscompares++;
                    $display("FAIL wrap_zero got=%0d exp=0", press_cnt);
                end
            end
        end
        vectors++;
        if (both_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_exclusive got=%b exp=0", both_seen);
        end
    endtask

    task automatic test_mid_reset();
        key_in = 1'b0;
        repeat (8) tick();
        vectors++;
        if (key_level !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_level got=%b exp=1", key_level);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (key_level !== 1'b0 || press_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset got=%b/%0d exp=0/0",
                     key_level, press_cnt);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (key_press !== (k == 6)) begin
                miscompares++;
                $display("FAIL mid_press[%0d] got=%b exp=%b",
                         k, key_press, (k == 6));
            end
        end
        vectors++;
        if (press_cnt !== 8'd1 || key_level !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_after got=%0d/%b exp=1/1",
                     press_cnt, key_level);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        both_seen   = 1'b0;
        exp_cnt     = 8'd0;
        rst_n       = 1'b0;
        key_in      = 1'b1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
